// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Round-robin front end sharing one sequential multiplier among
//            NREQ requesters, with result routing and hung-done recovery.
// Revision : 1.0  initial release
// ============================================================================
module mult_share_ctrl #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           gnt,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      mul_rst_n,
  output logic                      mul_en,
  output logic [WIDTH-1:0]          mul_a,
  output logic [WIDTH-1:0]          mul_b,
  input  logic                      mul_done,
  input  logic [2*WIDTH-1:0]        mul_m
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mul_en_q, mul_en_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic                 hit_hi, hit_lo;
  logic [IDW-1:0]       pick_hi, pick_lo, pick;
  logic                 gnt_en;
  logic [WIDTH-1:0]     sel_a, sel_b;

  // Requesters above the pointer win first; otherwise wrap to the lowest set one.
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !hit_hi && (i > int'(ptr_q))) begin
        hit_hi  = 1'b1;
        pick_hi = IDW'(i);
      end
      if (req[i] && !hit_lo) begin
        hit_lo  = 1'b1;
        pick_lo = IDW'(i);
      end
    end
    pick   = hit_hi ? pick_hi : pick_lo;
    gnt_en = !rst && (state_q == S_IDLE) && (|req);
    gnt    = gnt_en ? (NREQ'(1) << pick) : '0;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    mul_en_d    = mul_en_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_en) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          id_d     = pick;
          ptr_d    = pick;
          cnt_d    = '0;
          mul_en_d = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // Done is checked first so a completion on the limit cycle is kept.
        if (mul_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mul_m;
          rsp_id_d    = id_q;
          mul_en_d    = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          mul_en_d = 1'b0;
          state_d  = S_RECOVER;
        end
      end
      S_RECOVER: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
        rsp_id_d    = id_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // The multiplier is held in reset alongside us and for the single recovery cycle.
  assign mul_rst_n = !rst && (state_q != S_RECOVER);
  assign busy      = (state_q != S_IDLE);
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_ctrl
// Purpose  : Directed and randomized self-checking bench for mult_share_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_ctrl;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT_OK  = WIDTH + 5;
  localparam int LAT_TO  = TIMEOUT + 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   req_a, req_b;
  logic [NREQ-1:0]         gnt;
  logic                    rsp_valid, rsp_err, busy;
  logic [1:0]              rsp_id;
  logic [2*WIDTH-1:0]      rsp_data;
  logic                    mul_rst_n, mul_en, mul_done;
  logic [WIDTH-1:0]        mul_a, mul_b;
  logic [2*WIDTH-1:0]      mul_m;

  logic [WIDTH-1:0]        ra [NREQ];
  logic [WIDTH-1:0]        rb [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ra[i];
      req_b[i*WIDTH +: WIDTH] = rb[i];
    end
  end

  mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .mul_rst_n(mul_rst_n), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_m(mul_m)
  );

  // Sequential multiplier stand-in: done on the 12th enabled cycle unless stuck.
  bit stuck;
  int mcnt;
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      mcnt     <= 0;
      mul_done <= 1'b0;
    end else if (mul_en && !mul_done) begin
      if (mcnt == WIDTH + 2) begin
        mul_done <= !stuck;
        mul_m    <= $signed(mul_a) * $signed(mul_b);
        mcnt     <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mul_done <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: at most one operation in flight, described by its grant cycle.
  bit              op_act;
  int              op_gt, op_id, ptr = NREQ - 1;
  bit              op_stuck;
  logic [WIDTH-1:0] op_a, op_b;
  logic [NREQ-1:0] obs_gnt;
  int              gnt_cyc, rsp_cyc;
  bit              rsp_seen;
  logic [1:0]      last_id;
  logic [15:0]     last_data;
  logic            last_err;

  task automatic model_cycle();
    int end_c, pick, p_try, pa, pb;
    logic [NREQ-1:0] eg, rv;
    logic [15:0] e16;
    end_c = op_stuck ? op_gt + LAT_TO : op_gt + LAT_OK;
    if (op_act && cyc == end_c) begin
      pa  = $signed(op_a);
      pb  = $signed(op_b);
      e16 = op_stuck ? 16'h0 : 16'(pa * pb);
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_id", rsp_id, op_id);
      check_eq("rsp_err", rsp_err, op_stuck);
      check_eq("rsp_data", rsp_data, e16);
      op_act = 1'b0;
    end else begin
      check_eq("rsp_valid idle", rsp_valid, 0);
    end
    if (rsp_valid) begin
      rsp_seen  = 1'b1;
      rsp_cyc   = cyc;
      last_id   = rsp_id;
      last_data = rsp_data;
      last_err  = rsp_err;
    end
    check_eq("busy", busy, op_act);
    check_eq("mul_en", mul_en, op_act && (!op_stuck || cyc <= op_gt + TIMEOUT));
    check_eq("mul_rst_n", mul_rst_n,
             !rst && !(op_act && op_stuck && cyc == op_gt + TIMEOUT + 1));
    if (op_act) begin
      check_eq("mul_a", mul_a, op_a);
      check_eq("mul_b", mul_b, op_b);
    end
    eg   = '0;
    pick = -1;
    if (!rst && !op_act && req != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        p_try = (ptr + k) % NREQ;
        rv = req >> p_try;
        if (pick < 0 && rv[0]) pick = p_try;
      end
      eg = NREQ'(1) << pick;
    end
    check_eq("gnt", gnt, eg);
    obs_gnt = gnt;
    if (pick >= 0) begin
      op_act   = 1'b1;
      op_gt    = cyc;
      op_id    = pick;
      op_a     = ra[pick[1:0]];
      op_b     = rb[pick[1:0]];
      op_stuck = stuck;
      ptr      = pick;
      gnt_cyc  = cyc;
    end
    if (rst) begin
      op_act = 1'b0;
      ptr    = NREQ - 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_gnt(output int idx, output int c);
    int n;
    n   = 0;
    idx = -1;
    do begin
      step();
      n++;
    end while (obs_gnt == '0 && n < 200);
    check_eq("gnt seen", (obs_gnt != '0), 1);
    for (int i = 0; i < NREQ; i++) if (obs_gnt[i]) idx = i;
    c = gnt_cyc;
  endtask

  task automatic run_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [15:0] exp_data, input bit exp_err, input string tag);
    int idx, c, n;
    ra[id] = a;
    rb[id] = b;
    req    = NREQ'(1) << id;
    wait_gnt(idx, c);
    check_eq({tag, " gnt vec"}, obs_gnt, NREQ'(1) << id);
    req      = '0;
    rsp_seen = 1'b0;
    n        = 0;
    while (!rsp_seen && n < 200) begin
      step();
      n++;
    end
    check_eq({tag, " rsp seen"}, rsp_seen, 1);
    check_eq({tag, " latency"}, rsp_cyc - c, exp_err ? LAT_TO : LAT_OK);
    check_eq({tag, " id"}, last_id, id);
    check_eq({tag, " data"}, last_data, exp_data);
    check_eq({tag, " err"}, last_err, exp_err);
  endtask

  initial begin
    int idx, c, prev;
    rst   = 1'b1;
    req   = '0;
    stuck = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst gnt", gnt, 0);
    check_eq("rst rsp_valid", rsp_valid, 0);
    check_eq("rst rsp_err", rsp_err, 0);
    check_eq("rst rsp_id", rsp_id, 0);
    check_eq("rst rsp_data", rsp_data, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst mul_en", mul_en, 0);
    check_eq("rst mul_rst_n", mul_rst_n, 0);
    check_eq("rst mul_a", mul_a, 0);
    check_eq("rst mul_b", mul_b, 0);
    step();
    rst = 1'b0;

    run_op(1, 8'h05, 8'hFD, 16'hFFF1, 1'b0, "single");
    run_op(0, 8'h80, 8'h80, 16'h4000, 1'b0, "min*min");
    run_op(2, 8'h7F, 8'h80, 16'hC080, 1'b0, "max*min");

    // Fairness from a fresh pointer, then wrap-and-skip.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = WIDTH'($urandom);
      rb[i] = WIDTH'($urandom);
    end
    req  = 4'b1111;
    prev = 0;
    for (int g = 0; g < NREQ; g++) begin
      wait_gnt(idx, c);
      check_eq("rr order", idx, g);
      if (g > 0) check_eq("rr spacing", c - prev, LAT_OK);
      prev = c;
    end
    req = 4'b0101;
    wait_gnt(idx, c);
    check_eq("wrap first", idx, 0);
    wait_gnt(idx, c);
    check_eq("wrap skip", idx, 2);
    req = '0;
    repeat (LAT_OK + 2) step();

    stuck = 1'b1;
    run_op(2, 8'h12, 8'h34, 16'h0000, 1'b1, "timeout");
    stuck = 1'b0;
    run_op(3, 8'h03, 8'hFC, 16'hFFF4, 1'b0, "post-timeout");

    // Reset six cycles into an operation.
    ra[0] = 8'h11;
    rb[0] = 8'h22;
    req   = 4'b0001;
    wait_gnt(idx, c);
    req      = '0;
    rsp_seen = 1'b0;
    repeat (5) step();
    rst   = 1'b1;
    req   = 4'b1010;
    ra[1] = 8'h09;
    rb[1] = 8'hF7;
    ra[3] = 8'h21;
    rb[3] = 8'h02;
    step();
    check_eq("midrst busy", busy, 0);
    check_eq("midrst mul_rst_n", mul_rst_n, 0);
    check_eq("midrst gnt", gnt, 0);
    step();
    rst = 1'b0;
    check_eq("midrst no rsp", rsp_seen, 0);
    wait_gnt(idx, c);
    check_eq("post-rst grant", idx, 1);
    req = '0;
    repeat (LAT_OK + 2) step();

    // Randomized traffic with occasional hung multiplier and resets.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && obs_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
          ra[i]  = WIDTH'($urandom);
          rb[i]  = WIDTH'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          ra[i]  = WIDTH'($urandom);
          rb[i]  = WIDTH'($urandom);
        end
      end
      if (!op_act) stuck = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one sequential booth multiplier (en/A/B in, done/M out, active-low async reset) among NREQ requesters.
- Round-robin arbitration, operand capture, multiplier sequencing, result routing and done-timeout recovery.
- Sits between requester logic and the multiplier instance.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum BUSY cycles allowed before the multiplier is declared hung.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- req  input  NREQ  per-requester request level.
- req_a  input  NREQ*WIDTH  operand A of requester i in bits [i*WIDTH +: WIDTH], two's complement.
- req_b  input  NREQ*WIDTH  operand B, same packing.
- gnt  output  NREQ  one-hot, one-cycle grant pulse; operands captured this cycle.
- rsp_valid  output  1  one-cycle result pulse.
- rsp_id  output  $clog2(NREQ)  requester index for the current rsp_valid.
- rsp_data  output  2*WIDTH  signed product; 0 when rsp_err=1.
- rsp_err  output  1  result aborted by timeout; qualified by rsp_valid.
- busy  output  1  high in every state other than IDLE.
- mul_rst_n  output  1  multiplier reset, active-low.
- mul_en  output  1  multiplier enable.
- mul_a  output  WIDTH  operand A to multiplier.
- mul_b  output  WIDTH  operand B to multiplier.
- mul_done  input  1  multiplier done pulse.
- mul_m  input  2*WIDTH  multiplier product.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst=1 forces state IDLE.
  - gnt, rsp_valid, rsp_err, mul_en and busy go to 0; rsp_id, rsp_data, mul_a and mul_b go to 0.
  - RR pointer is set to NREQ-1, so req[0] has highest priority first.
  - mul_rst_n=0 while rst=1; mul_rst_n=1 from the first cycle after rst deasserts.
  - rst mid-operation abandons the operation with no rsp_valid.
- Requester rules:
  - Hold req and operands stable until gnt. Dropping req before gnt is legal; nothing is issued.
  - req still high the cycle after gnt counts as a new request.
- IDLE:
  - If any req is set, gnt (combinational) goes to the first set requester at or after pointer+1, wrapping mod NREQ.
  - On that edge: operands are latched into mul_a/mul_b, the index is latched, the pointer is set to the granted index, the timeout counter is cleared, and the state goes to BUSY.
  - No req: stay in IDLE.
- BUSY:
  - mul_en=1 with mul_a/mul_b held constant; the timeout counter increments each cycle.
  - mul_done=1: capture mul_m into rsp_data and set rsp_id. Next cycle rsp_valid=1, rsp_err=0, state IDLE, mul_en=0.
  - mul_en stays high in the done cycle so the multiplier returns to its idle state. It is low the following cycle so the multiplier does not relaunch.
  - Counter reaches TIMEOUT-1 without mul_done: go to RECOVER.
- RECOVER (1 cycle):
  - mul_en=0, mul_rst_n=0.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0, rsp_id=granted index, state IDLE.
  - mul_done in the same cycle as the timeout limit: done wins, normal response.
- Latency and throughput:
  - With WIDTH=8, gnt at cycle T gives mul_done at T+12 and rsp_valid at T+13 (grant-to-response = WIDTH+5).
  - IDLE can grant in the same cycle rsp_valid is high, so back-to-back operations run every WIDTH+5 cycles.
- Other rules:
  - rsp_data and rsp_id hold their value until the next response.
  - mul_done outside BUSY is ignored.

Test Plan:
- Single op, WIDTH=8: req[1] with a=8'h05, b=8'hFD -> gnt=4'b0010 at T; rsp_valid at T+13, rsp_id=1, rsp_data=16'hFFF1, rsp_err=0.
- Extreme operands: a=8'h80, b=8'h80 -> rsp_data=16'h4000. a=8'h7F, b=8'h80 -> rsp_data=16'hC080.
- Fairness: req=4'b1111 held continuously -> grants in order 0,1,2,3,0, spaced 13 cycles; each rsp_id matches its grant.
- Wrap and skip: after a grant to 3, req=4'b0101 -> next grant 0, then 2.
- Timeout: multiplier model with mul_done stuck at 0 -> mul_en high for 64 cycles, then one cycle of mul_rst_n=0, then rsp_valid=1 with rsp_err=1 and rsp_data=0; the next request completes normally.
- Reset mid-BUSY: assert rst at T+6 -> no rsp_valid, mul_rst_n=0 and busy=0 during rst; first grant after reset goes to the lowest-index pending req.
